// File: rtl/register_file.sv
// Multi-ported register file: 4 A, 4 B and 2 C combinational read ports, 4 write ports.
// `define RF_WRITE_BYPASS_EN forwards same-cycle write data to every read port.
module register_file #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int IP_OFFSET     = 2
) (
    input  logic                                clk_i,
    input  logic                                arst_i,
    input  logic [3:0][ADDRESS_WIDTH-1:0]       select_a_i,
    input  logic [3:0][ADDRESS_WIDTH-1:0]       select_b_i,
    input  logic [1:0][ADDRESS_WIDTH-1:0]       select_c_i,
    input  logic [3:0][ADDRESS_WIDTH-1:0]       select_r_i,
    input  logic [3:0][WORD_WIDTH-1:0]          data_i,
    input  logic [3:0]                          enable_writing_i,
    output logic [3:0][WORD_WIDTH-1:0]          a_o,
    output logic [3:0][WORD_WIDTH-1:0]          b_o,
    output logic [1:0][WORD_WIDTH-2:0]          c_o,
    output logic [WORD_WIDTH-1:0]               ip_o
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] IP_ADDR = ADDRESS_WIDTH'(IP_OFFSET);

    logic [WORD_WIDTH-1:0] regs_q [NUM_REGS];
    logic [WORD_WIDTH-1:0] regs_d [NUM_REGS];
    logic [WORD_WIDTH-1:0] view   [NUM_REGS];

    // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < 4; k++) begin
            if (enable_writing_i[k]) begin
                regs_d[select_r_i[k]] = data_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    // Next-state array already carries the write data with the right priority.
    assign view = regs_d;
`else
    assign view = regs_q;
`endif

    always_comb begin
        a_o  = '0;
        b_o  = '0;
        c_o  = '0;
        ip_o = '0;
        if (arst_i) begin
            for (int i = 0; i < 4; i++) begin
                a_o[i] = view[select_a_i[i]];
                b_o[i] = view[select_b_i[i]];
            end
            for (int j = 0; j < 2; j++) begin
                c_o[j] = view[select_c_i[j]][WORD_WIDTH-2:0];
            end
            ip_o = view[IP_ADDR];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 32x32, IP at index 2).
module tb_register_file;

    logic                clk_i;
    logic                arst_i;
    logic [3:0][4:0]     select_a_i;
    logic [3:0][4:0]     select_b_i;
    logic [1:0][4:0]     select_c_i;
    logic [3:0][4:0]     select_r_i;
    logic [3:0][31:0]    data_i;
    logic [3:0]          enable_writing_i;
    logic [3:0][31:0]    a_o;
    logic [3:0][31:0]    b_o;
    logic [1:0][30:0]    c_o;
    logic [31:0]         ip_o;

    int n_cmp = 0;
    int n_err = 0;

    register_file #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .IP_OFFSET(2)) dut (
        .clk_i(clk_i),
        .arst_i(arst_i),
        .select_a_i(select_a_i),
        .select_b_i(select_b_i),
        .select_c_i(select_c_i),
        .select_r_i(select_r_i),
        .data_i(data_i),
        .enable_writing_i(enable_writing_i),
        .a_o(a_o),
        .b_o(b_o),
        .c_o(c_o),
        .ip_o(ip_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        arst_i           = 1'b0;
        select_a_i       = {5'd3, 5'd2, 5'd1, 5'd0};
        select_b_i       = {5'd3, 5'd2, 5'd1, 5'd0};
        select_c_i       = {5'd1, 5'd0};
        select_r_i       = {5'd3, 5'd2, 5'd1, 5'd0};
        data_i           = {32'h11, 32'h22, 32'h33, 32'h44};
        enable_writing_i = 4'hF;
        #1;
        chk("reset_a", a_o, 128'h0);
        chk("reset_ip", 128'(ip_o), 128'h0);
        chk("reset_c", 128'(c_o), 128'h0);

        // Writes held during reset must be dropped.
        edge_then_settle();
        chk("reset_write_ignored", a_o, 128'h0);

        @(negedge clk_i);
        arst_i           = 1'b1;
        data_i           = {32'd3, 32'd2, 32'd1, 32'd0};
        enable_writing_i = 4'hF;
        #1;
        chk("pre_edge_stored_zero", a_o, 128'h0);
        edge_then_settle();
        chk("write_all_a", a_o, {32'd3, 32'd2, 32'd1, 32'd0});
        chk("write_all_ip", 128'(ip_o), 128'd2);

        @(negedge clk_i);
        enable_writing_i = 4'b0001;
        data_i           = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'd4};
        edge_then_settle();
        chk("single_port0_a", a_o, {32'd3, 32'd2, 32'd1, 32'd4});
        chk("single_port0_b", b_o, {32'd3, 32'd2, 32'd1, 32'd4});

        @(negedge clk_i);
        enable_writing_i = 4'b1010;
        select_r_i       = {5'd7, 5'd0, 5'd7, 5'd0};
        data_i           = {32'h55, 32'h0, 32'hAA, 32'h0};
        edge_then_settle();
        select_b_i = {5'd3, 5'd2, 5'd1, 5'd7};
        #1;
        chk("collision_1_3", 128'(b_o[0]), 128'h55);
        chk("collision_others", a_o, {32'd3, 32'd2, 32'd1, 32'd4});

        @(negedge clk_i);
        enable_writing_i = 4'b0111;
        select_r_i       = {5'd0, 5'd8, 5'd8, 5'd8};
        data_i           = {32'h0, 32'hC2, 32'hB1, 32'hA0};
        edge_then_settle();
        select_b_i = {5'd3, 5'd2, 5'd8, 5'd7};
        #1;
        chk("collision_0_1_2", 128'(b_o[1]), 128'hC2);

        @(negedge clk_i);
        enable_writing_i = 4'b0110;
        select_r_i       = {5'd0, 5'd5, 5'd2, 5'd0};
        data_i           = {32'h0, 32'hFFFF_FFFF, 32'h1234, 32'h0};
        edge_then_settle();
        select_c_i = {5'd0, 5'd5};
        #1;
        chk("c_msb_dropped", 128'(c_o[0]), 128'h7FFF_FFFF);
        chk("c_reg0", 128'(c_o[1]), 128'h4);
        chk("ip_rewritten", 128'(ip_o), 128'h1234);

        @(negedge clk_i);
        enable_writing_i = 4'b1000;
        select_r_i       = {5'd9, 5'd0, 5'd0, 5'd0};
        data_i           = {32'h10, 32'h0, 32'h0, 32'h0};
        edge_then_settle();

        @(negedge clk_i);
        enable_writing_i = 4'b0001;
        select_r_i       = {5'd0, 5'd0, 5'd0, 5'd9};
        data_i           = {32'h0, 32'h0, 32'h0, 32'h20};
        select_a_i       = {5'd3, 5'd2, 5'd1, 5'd9};
        select_c_i       = {5'd9, 5'd5};
        #1;
`ifdef RF_WRITE_BYPASS_EN
        chk("rdw_before_edge_a", 128'(a_o[0]), 128'h20);
        chk("rdw_before_edge_c", 128'(c_o[1]), 128'h20);
`else
        chk("rdw_before_edge_a", 128'(a_o[0]), 128'h10);
        chk("rdw_before_edge_c", 128'(c_o[1]), 128'h10);
`endif
        edge_then_settle();
        chk("rdw_after_edge", 128'(a_o[0]), 128'h20);

        enable_writing_i = 4'b0000;
        #2;
        arst_i = 1'b0;
        #1;
        chk("midcycle_reset_a", a_o, 128'h0);
        chk("midcycle_reset_b", b_o, 128'h0);
        chk("midcycle_reset_c", 128'(c_o), 128'h0);
        chk("midcycle_reset_ip", 128'(ip_o), 128'h0);

        @(negedge clk_i);
        arst_i = 1'b1;
        #1;
        chk("cleared_after_reset_a", a_o, 128'h0);
        chk("cleared_after_reset_c", 128'(c_o), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
